// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the multi-button controller:
//   - 2-bit encoding of the per-channel FSM states
//   - enum view of that encoding for readable RTL
//   - parameter legality check used at elaboration by the top level
// ---------------------------------------------------------------------------
package button_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE       = ST_IDLE,
        S_PRESS_DB   = ST_PRESS_DB,
        S_HELD       = ST_HELD,
        S_RELEASE_DB = ST_RELEASE_DB
    } state_t;

    // True when the parameter set describes a buildable controller.
    function automatic bit params_legal(input int n_btn,
                                        input int debounce_cyc,
                                        input int long_cyc,
                                        input int repeat_cyc);
        return (n_btn >= 1) && (n_btn <= 16) &&
               (debounce_cyc >= 2) &&
               (long_cyc > debounce_cyc) &&
               (repeat_cyc >= 2);
    endfunction

endpackage

// File: rtl/button_channel.sv
// ---------------------------------------------------------------------------
// button_channel
// One button: two-flop synchroniser, debounce FSM, long-press and
// auto-repeat timing. All outputs are registered.
//
// Ports
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   i_button   raw asynchronous button level (1 = pushed)
//   o_level    debounced level
//   o_press    one-cycle pulse on accepted press
//   o_release  one-cycle pulse on accepted release
//   o_click    one-cycle pulse with o_release when no long event fired
//   o_long     one-cycle pulse when the hold time reaches LONG_CYC
//   o_repeat   one-cycle pulse every REPEAT_CYC after o_long (if enabled)
// ---------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50_000,
    parameter int LONG_CYC     = 5_000_000,
    parameter int REPEAT_CYC   = 1_000_000,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long,
    output logic o_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC + REPEAT_CYC);
    localparam int REP_W  = $clog2(REPEAT_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC + REPEAT_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    logic [1:0]        r_sync;
    state_t            r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_long_fired;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_click;
    logic              r_long;
    logic              r_repeat;

    logic              w_sync;
    state_t            w_state_nxt;
    logic [DB_W-1:0]   w_db_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [REP_W-1:0]  w_rep_nxt;
    logic              w_long_fired_nxt;
    logic              w_level_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_click_nxt;
    logic              w_long_nxt;
    logic              w_repeat_nxt;

    assign w_sync = r_sync[1];

    always_comb begin
        w_state_nxt      = r_state;
        w_db_nxt         = r_db_cnt;
        w_hold_nxt       = r_hold_cnt;
        w_rep_nxt        = r_rep_cnt;
        w_long_fired_nxt = r_long_fired;
        w_level_nxt      = r_level;
        w_press_nxt      = 1'b0;
        w_release_nxt    = 1'b0;
        w_click_nxt      = 1'b0;
        w_long_nxt       = 1'b0;
        w_repeat_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_sync) begin
                    w_state_nxt = S_PRESS_DB;
                    w_db_nxt    = '0;
                end
            end

            S_PRESS_DB: begin
                if (!w_sync) begin
                    w_state_nxt = S_IDLE;
                    w_db_nxt    = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    // Fresh press: hold/repeat timing starts from zero.
                    w_state_nxt      = S_HELD;
                    w_press_nxt      = 1'b1;
                    w_level_nxt      = 1'b1;
                    w_hold_nxt       = '0;
                    w_rep_nxt        = '0;
                    w_long_fired_nxt = 1'b0;
                end else begin
                    w_db_nxt = r_db_cnt + DB_ONE;
                end
            end

            S_HELD: begin
                if (!w_sync) begin
                    // Hold and repeat counters freeze while the release is
                    // being qualified, so a bounce resumes where it left off.
                    w_state_nxt = S_RELEASE_DB;
                    w_db_nxt    = '0;
                end else begin
                    if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_nxt = r_hold_cnt + HOLD_ONE;
                    end
                    if (!r_long_fired) begin
                        if (r_hold_cnt == LONG_LAST) begin
                            w_long_nxt       = 1'b1;
                            w_long_fired_nxt = 1'b1;
                            w_rep_nxt        = '0;
                        end
                    end else if (REPEAT_EN) begin
                        if (r_rep_cnt == REP_LAST) begin
                            w_repeat_nxt = 1'b1;
                            w_rep_nxt    = '0;
                        end else begin
                            w_rep_nxt = r_rep_cnt + REP_ONE;
                        end
                    end
                end
            end

            S_RELEASE_DB: begin
                if (w_sync) begin
                    w_state_nxt = S_HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                    w_click_nxt   = !r_long_fired;
                    w_level_nxt   = 1'b0;
                    w_db_nxt      = '0;
                end else begin
                    w_db_nxt = r_db_cnt + DB_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_db_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync       <= '0;
            r_state      <= S_IDLE;
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_rep_cnt    <= '0;
            r_long_fired <= 1'b0;
            r_level      <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_click      <= 1'b0;
            r_long       <= 1'b0;
            r_repeat     <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_button};
            r_state      <= w_state_nxt;
            r_db_cnt     <= w_db_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_rep_cnt    <= w_rep_nxt;
            r_long_fired <= w_long_fired_nxt;
            r_level      <= w_level_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_click      <= w_click_nxt;
            r_long       <= w_long_nxt;
            r_repeat     <= w_repeat_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_click   = r_click;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/multi_button_controller.sv
// ---------------------------------------------------------------------------
// multi_button_controller
// N_BTN independent debounced buttons with press/release/click/long-press
// and optional auto-repeat events.
//
// Ports
//   i_clk      clock
//   i_reset    synchronous active-high reset
//   i_button   raw asynchronous button levels, one bit per channel
//   o_level    debounced levels
//   o_press    press pulses
//   o_release  release pulses
//   o_click    short-press pulses (coincide with o_release)
//   o_long     long-press pulses
//   o_repeat   auto-repeat pulses (only on REPEAT_EN channels)
// ---------------------------------------------------------------------------
module multi_button_controller
    import button_pkg::*;
#(
    parameter int               N_BTN        = 4,
    parameter int               DEBOUNCE_CYC = 50_000,
    parameter int               LONG_CYC     = 5_000_000,
    parameter int               REPEAT_CYC   = 1_000_000,
    parameter logic [N_BTN-1:0] REPEAT_EN    = {N_BTN{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_button,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_click,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat
);

    generate
        if (!params_legal(N_BTN, DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) begin : g_bad_params
            $error("multi_button_controller: illegal parameter set");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            button_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .LONG_CYC     (LONG_CYC),
                .REPEAT_CYC   (REPEAT_CYC),
                .REPEAT_EN    (REPEAT_EN[gi])
            ) u_channel (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_button  (i_button[gi]),
                .o_level   (o_level[gi]),
                .o_press   (o_press[gi]),
                .o_release (o_release[gi]),
                .o_click   (o_click[gi]),
                .o_long    (o_long[gi]),
                .o_repeat  (o_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_button_controller.sv
// ---------------------------------------------------------------------------
// Testbench for multi_button_controller (DEBOUNCE_CYC=4, LONG_CYC=20,
// REPEAT_CYC=8, N_BTN=4, REPEAT_EN=4'b0010).
// The reference model works on the synchronised sample stream: a level
// change is accepted after DEBOUNCE_CYC+1 consecutive equal samples, hold
// time counts cycles where the button stayed down across two samples, and
// long/repeat events are fixed points on that hold-time axis.
// ---------------------------------------------------------------------------
module tb_multi_button_controller;

    localparam int         N   = 4;
    localparam int         D   = 4;
    localparam int         L   = 20;
    localparam int         R   = 8;
    localparam logic [3:0] REN = 4'b0010;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] lvl, prs, rls, clk_ev, lng, rpt;

    always #5 clk = ~clk;

    multi_button_controller #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (D),
        .LONG_CYC     (L),
        .REPEAT_CYC   (R),
        .REPEAT_EN    (REN)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_button  (btn),
        .o_level   (lvl),
        .o_press   (prs),
        .o_release (rls),
        .o_click   (clk_ev),
        .o_long    (lng),
        .o_repeat  (rpt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_s1[N], m_s2[N], m_prev[N], m_lvl[N];
    int           m_run1[N], m_run0[N], m_ticks[N];
    logic [N-1:0] e_lvl, e_prs, e_rls, e_clk, e_lng, e_rpt;
    bit           armed = 1'b0;
    int           edge_cnt = 0;
    bit           s;

    always @(posedge clk) begin
        edge_cnt++;
        e_prs = '0; e_rls = '0; e_clk = '0; e_lng = '0; e_rpt = '0;
        if (rst) begin
            armed = 1'b1;
            for (int c = 0; c < N; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_prev[c] = 0; m_lvl[c] = 0;
                m_run1[c] = 0; m_run0[c] = 0; m_ticks[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                s = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = btn[c];
                if (s) begin m_run1[c]++; m_run0[c] = 0; end
                else   begin m_run0[c]++; m_run1[c] = 0; end
                if (!m_lvl[c]) begin
                    if (s && m_run1[c] == D + 1) begin
                        e_prs[c] = 1'b1; m_lvl[c] = 1; m_ticks[c] = 0;
                    end
                end else if (s && m_prev[c]) begin
                    m_ticks[c]++;
                    if (m_ticks[c] == L) e_lng[c] = 1'b1;
                    if (REN[c] && m_ticks[c] > L && ((m_ticks[c] - L) % R) == 0) e_rpt[c] = 1'b1;
                end else if (!s && m_run0[c] == D + 1) begin
                    e_rls[c] = 1'b1; e_clk[c] = (m_ticks[c] < L); m_lvl[c] = 0;
                end
                m_prev[c] = s;
            end
        end
        for (int c = 0; c < N; c++) e_lvl[c] = m_lvl[c];
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (armed) begin
            check("cmp_level",   32'(lvl),    32'(e_lvl));
            check("cmp_press",   32'(prs),    32'(e_prs));
            check("cmp_release", 32'(rls),    32'(e_rls));
            check("cmp_click",   32'(clk_ev), 32'(e_clk));
            check("cmp_long",    32'(lng),    32'(e_lng));
            check("cmp_repeat",  32'(rpt),    32'(e_rpt));
        end
    end

    // ---------------- event log for literal timing checks ----------------
    // kinds: 0 press, 1 release, 2 click, 3 long, 4 repeat, 5 level-high cycles
    int         ev_cnt[N][6], ev_first[N][6], ev_last[N][6];
    int         log_base = 0;
    int         rel_now;
    logic [5:0] lg_ev;

    always @(negedge clk) begin
        rel_now = edge_cnt - log_base - 1;
        if (rel_now >= 0) begin
            for (int c = 0; c < N; c++) begin
                lg_ev = {lvl[c], rpt[c], lng[c], clk_ev[c], rls[c], prs[c]};
                for (int k = 0; k < 6; k++) begin
                    if (lg_ev[k] === 1'b1) begin
                        if (ev_cnt[c][k] == 0) ev_first[c][k] = rel_now;
                        ev_last[c][k] = rel_now;
                        ev_cnt[c][k]++;
                    end
                end
            end
        end
    end

    task automatic clear_log();
        log_base = edge_cnt;
        for (int c = 0; c < N; c++)
            for (int k = 0; k < 6; k++) begin
                ev_cnt[c][k] = 0; ev_first[c][k] = -1; ev_last[c][k] = -1;
            end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int rem[N];

    initial begin
        rst = 1'b1;
        btn = '0;
        clear_log();
        wait_neg(3);
        check("reset_outputs", 32'({lvl, prs, rls, clk_ev, lng, rpt}), 32'd0);
        rst = 1'b0;
        wait_neg(5);

        // Short press on channel 0.
        clear_log();
        btn[0] = 1'b1; wait_neg(10);
        btn[0] = 1'b0; wait_neg(12);
        check("t1_press_cnt",    ev_cnt[0][0],   1);
        check("t1_press_edge",   ev_first[0][0], 6);
        check("t1_release_edge", ev_first[0][1], 16);
        check("t1_click_edge",   ev_first[0][2], 16);
        check("t1_long_cnt",     ev_cnt[0][3],   0);
        check("t1_level_cycles", ev_cnt[0][5],   10);

        // Glitches of 3 cycles every 5 cycles on channel 0.
        clear_log();
        repeat (6) begin
            btn[0] = 1'b1; wait_neg(3);
            btn[0] = 1'b0; wait_neg(2);
        end
        wait_neg(10);
        check("t2_press_cnt",   ev_cnt[0][0], 0);
        check("t2_release_cnt", ev_cnt[0][1], 0);
        check("t2_level_cnt",   ev_cnt[0][5], 0);

        // Long holds on channel 1 (repeat) and channel 2 (no repeat).
        clear_log();
        btn = 4'b0110; wait_neg(45);
        btn = 4'b0000; wait_neg(10);
        check("t3_press_edge",    ev_first[1][0], 6);
        check("t3_long_cnt",      ev_cnt[1][3],   1);
        check("t3_long_edge",     ev_first[1][3], 26);
        check("t3_repeat_cnt",    ev_cnt[1][4],   2);
        check("t3_repeat_first",  ev_first[1][4], 34);
        check("t3_repeat_last",   ev_last[1][4],  42);
        check("t3_release_edge",  ev_first[1][1], 51);
        check("t3_click_cnt",     ev_cnt[1][2],   0);
        check("t4_long_cnt",      ev_cnt[2][3],   1);
        check("t4_long_edge",     ev_first[2][3], 26);
        check("t4_repeat_cnt",    ev_cnt[2][4],   0);
        check("t4_click_cnt",     ev_cnt[2][2],   0);

        // Channels 0 and 3 together, 2-cycle release bounce on channel 3.
        clear_log();
        btn = 4'b1001; wait_neg(12);
        btn[3] = 1'b0; wait_neg(2);
        btn[3] = 1'b1; wait_neg(6);
        btn = 4'b0000; wait_neg(10);
        check("t5_press_edge0",   ev_first[0][0], 6);
        check("t5_press_edge3",   ev_first[3][0], 6);
        check("t5_press_cnt3",    ev_cnt[3][0],   1);
        check("t5_release_cnt3",  ev_cnt[3][1],   1);
        check("t5_release_edge3", ev_first[3][1], 26);
        check("t5_click_cnt3",    ev_cnt[3][2],   1);
        check("t5_long_cnt3",     ev_cnt[3][3],   0);

        // Reset while channel 0 is held.
        btn[0] = 1'b1; wait_neg(15);
        check("t6_level_before", 32'(lvl[0]), 32'd1);
        clear_log();
        rst = 1'b1; wait_neg(1);
        check("t6_reset_outputs", 32'({lvl, prs, rls, clk_ev, lng, rpt}), 32'd0);
        rst = 1'b0; wait_neg(12);
        check("t6_release_cnt", ev_cnt[0][1],   0);
        check("t6_click_cnt",   ev_cnt[0][2],   0);
        check("t6_press_cnt",   ev_cnt[0][0],   1);
        check("t6_press_edge",  ev_first[0][0], 7);
        btn = '0; wait_neg(10);

        // Randomised activity on all channels with occasional reset.
        for (int c = 0; c < N; c++) rem[c] = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                         : int'($urandom_range(1, 8));
                end
            end
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
        btn = '0;
        wait_neg(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
